pipeline_stage_skid: RTL

- Parametrised successor to the fixed M/W pipeline register: a generic pipeline stage register with valid/ready handshake, a two-entry skid buffer and a synchronous flush.
- Sits between any two core pipeline stages (D/E, E/M, M/W).
- Payload is split into a control field, cleared whenever its entry is invalid or flushed, and a data field.
- Control bits such as RegWrite/MemWrite therefore never leak from a bubble or a squashed instruction.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_counter.sv | 31 +++
 rtl/pipeline_stage_skid.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline stage register.
//   - pipeState_e : occupancy state of a stage (EMPTY / ONE / FULL)
//   - default control/data payload widths for each core stage boundary
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Encoding is fixed: the value 3 is illegal and must recover to ST_EMPTY.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipeState_e;

   // D/E boundary: control = RegWrite, MemtoReg, MemWrite, Jump, Branch,
   // ALUControl[2:0], ALUSrc; data = RD1, RD2, PC, ImmExt, rd, PCPlus4.
   localparam int DE_CTRL_W = 9;
   localparam int DE_DATA_W = 32 + 32 + 32 + 32 + 5 + 32;

   // E/M boundary: control = RegWrite, MemtoReg, MemWrite;
   // data = ALUResult, WriteData, rd.
   localparam int EM_CTRL_W = 3;
   localparam int EM_DATA_W = 32 + 32 + 5;

   // M/W boundary: control = RegWrite, MemtoReg;
   // data = ReadData, ComputeResult, rd.
   localparam int MW_CTRL_W = 2;
   localparam int MW_DATA_W = 32 + 32 + 5;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for stage performance statistics.
// Ports:
//   CLK    in   clock
//   RESET  in   synchronous active-high clear
//   inc    in   count enable for this cycle
//   count  out  W-bit count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic atMax;

   assign atMax = (count == {W{1'b1}});

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count <= '0;
      end else if (inc && !atMax) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/pipeline_stage_skid.sv
// -----------------------------------------------------------------------------
// pipeline_stage_skid
// Generic pipeline stage register with valid/ready handshake, a two-entry
// (main + skid) buffer and a synchronous flush. All outputs come straight
// from registers; nothing from in_* or out_ready reaches an output
// combinationally. Control payload is zeroed whenever its entry is invalid
// so a bubble or squashed instruction can never assert RegWrite/MemWrite.
//
// Optional feature macro: PIPE_STAGE_PERF_EN (adds stall/bubble counters).
//
// Ports:
//   CLK         in   clock
//   RESET       in   synchronous active-high reset
//   flush       in   squash all held entries this cycle
//   in_valid    in   upstream beat valid
//   in_ready    out  stage can accept (registered: state != FULL)
//   in_ctrl     in   upstream control payload   [CTRL_W]
//   in_data     in   upstream data payload      [DATA_W]
//   out_valid   out  main entry valid (state != EMPTY)
//   out_ready   in   downstream accepts
//   out_ctrl    out  main-entry control, 0 when out_valid=0
//   out_data    out  main-entry data
//   stall_cnt   out  cycles with out_valid & !out_ready  (PIPE_STAGE_PERF_EN)
//   bubble_cnt  out  cycles with !out_valid              (PIPE_STAGE_PERF_EN)
//
// State      | meaning
// -----------+-----------------------------------------------------------
// ST_EMPTY   | nothing held; out_valid=0, in_ready=1
// ST_ONE     | main entry valid, skid empty; in_ready=1
// ST_FULL    | main and skid valid, skid is the younger beat; in_ready=0
// -----------------------------------------------------------------------------
module pipeline_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = MW_DATA_W,
   parameter int CTRL_W = MW_CTRL_W,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   // Degenerate widths are a configuration error, caught at elaboration.
   if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : gBadParams
      $error("pipeline_stage_skid: DATA_W, CTRL_W and CNT_W must be >= 1");
   end

   pipeState_e        stateQ,    stateNext;
   logic [CTRL_W-1:0] mainCtrlQ, mainCtrlNext;
   logic [DATA_W-1:0] mainDataQ, mainDataNext;
   logic [CTRL_W-1:0] skidCtrlQ, skidCtrlNext;
   logic [DATA_W-1:0] skidDataQ, skidDataNext;

   logic outValid;
   logic inReady;
   logic inFire;
   logic outFire;

   assign outValid = (stateQ != ST_EMPTY);
   assign inReady  = (stateQ != ST_FULL);
   assign inFire   = in_valid & inReady;
   assign outFire  = outValid & out_ready;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stateQ    <= ST_EMPTY;
         mainCtrlQ <= '0;
         mainDataQ <= '0;
         skidCtrlQ <= '0;
         skidDataQ <= '0;
      end else begin
         stateQ    <= stateNext;
         mainCtrlQ <= mainCtrlNext;
         mainDataQ <= mainDataNext;
         skidCtrlQ <= skidCtrlNext;
         skidDataQ <= skidDataNext;
      end
   end

   // Data fields are never cleared here; only their ctrl companions are,
   // so an invalid entry carries a stale but harmless data value.
   always_comb begin
      stateNext    = stateQ;
      mainCtrlNext = mainCtrlQ;
      mainDataNext = mainDataQ;
      skidCtrlNext = skidCtrlQ;
      skidDataNext = skidDataQ;

      if (flush) begin
         // Any beat accepted this cycle is dropped; an out_fire this cycle
         // still counts as taken downstream, so nothing is replayed.
         stateNext    = ST_EMPTY;
         mainCtrlNext = '0;
         skidCtrlNext = '0;
      end else begin
         unique case (stateQ)
            ST_EMPTY: begin
               if (inFire) begin
                  stateNext    = ST_ONE;
                  mainCtrlNext = in_ctrl;
                  mainDataNext = in_data;
               end
            end
            ST_ONE: begin
               if (inFire && outFire) begin
                  mainCtrlNext = in_ctrl;
                  mainDataNext = in_data;
               end else if (inFire) begin
                  stateNext    = ST_FULL;
                  skidCtrlNext = in_ctrl;
                  skidDataNext = in_data;
               end else if (outFire) begin
                  stateNext    = ST_EMPTY;
                  mainCtrlNext = '0;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so the skid entry is always the
               // older of any beat still waiting upstream.
               if (outFire) begin
                  stateNext    = ST_ONE;
                  mainCtrlNext = skidCtrlQ;
                  mainDataNext = skidDataQ;
                  skidCtrlNext = '0;
               end
            end
            default: begin
               stateNext    = ST_EMPTY;
               mainCtrlNext = '0;
               skidCtrlNext = '0;
            end
         endcase
      end
   end

   assign in_ready  = inReady;
   assign out_valid = outValid;
   assign out_ctrl  = mainCtrlQ;
   assign out_data  = mainDataQ;

`ifdef PIPE_STAGE_PERF_EN
   logic stallInc;
   logic bubbleInc;

   assign stallInc  = outValid & ~out_ready;
   assign bubbleInc = ~outValid;

   sat_counter #(.W(CNT_W)) uStallCnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (stallInc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) uBubbleCnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (bubbleInc),
      .count (bubble_cnt)
   );
`endif

endmodule : pipeline_stage_skid
